// File: rtl/voxel_write_arbiter.sv
// Merges the world generator's write stream with buffered host voxel edits onto one memory write port.
// Generator writes always win; host edits wait in a small FIFO and drain into idle slots.
module voxel_write_arbiter #(
    parameter int FIFO_DEPTH      = 4,
    parameter bit LOCK_DURING_GEN = 1'b1,
    localparam int LVL_W          = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W          = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gen_write_en,
    input  logic [17:0]      gen_write_addr,
    input  logic [63:0]      gen_write_data,
    input  logic             gen_busy,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [17:0]      host_addr,
    input  logic [63:0]      host_data,
    output logic             mem_write_en,
    output logic [17:0]      mem_write_addr,
    output logic [63:0]      mem_write_data,
    output logic [LVL_W-1:0] fifo_level,
    output logic [19:0]      gen_count,
    output logic [19:0]      host_count,
    input  logic             stat_clear
);

    logic [17:0]      fifo_addr_mem [FIFO_DEPTH];
    logic [63:0]      fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic             host_ready_reg;
    logic             host_ready_next;
    logic             mem_write_en_reg;
    logic [17:0]      mem_write_addr_reg;
    logic [63:0]      mem_write_data_reg;
    logic [19:0]      gen_count_reg;
    logic [19:0]      host_count_reg;
    logic             push;
    logic             pop;

    // Ready is registered, so a full FIFO refuses an edit even when a pop frees a slot this cycle.
    always_comb begin
        push            = host_valid && host_ready_reg;
        pop             = (level_reg != '0) && !gen_write_en && !(LOCK_DURING_GEN && gen_busy);
        level_next      = level_reg + LVL_W'(push) - LVL_W'(pop);
        host_ready_next = (level_next < LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[tail_reg] <= host_addr;
            fifo_data_mem[tail_reg] <= host_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg           <= '0;
            tail_reg           <= '0;
            level_reg          <= '0;
            host_ready_reg     <= 1'b0;
            mem_write_en_reg   <= 1'b0;
            mem_write_addr_reg <= '0;
            mem_write_data_reg <= '0;
            gen_count_reg      <= '0;
            host_count_reg     <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            level_reg      <= level_next;
            host_ready_reg <= host_ready_next;

            if (gen_write_en) begin
                mem_write_en_reg   <= 1'b1;
                mem_write_addr_reg <= gen_write_addr;
                mem_write_data_reg <= gen_write_data;
            end else if (pop) begin
                mem_write_en_reg   <= 1'b1;
                mem_write_addr_reg <= fifo_addr_mem[head_reg];
                mem_write_data_reg <= fifo_data_mem[head_reg];
            end else begin
                mem_write_en_reg   <= 1'b0;
            end

            // Clear takes precedence over a same-cycle increment.
            if (stat_clear) begin
                gen_count_reg  <= '0;
                host_count_reg <= '0;
            end else begin
                if (gen_write_en && (gen_count_reg != '1)) begin
                    gen_count_reg <= gen_count_reg + 20'd1;
                end
                if (pop && (host_count_reg != '1)) begin
                    host_count_reg <= host_count_reg + 20'd1;
                end
            end
        end
    end

    assign host_ready     = host_ready_reg;
    assign mem_write_en   = mem_write_en_reg;
    assign mem_write_addr = mem_write_addr_reg;
    assign mem_write_data = mem_write_data_reg;
    assign fifo_level     = level_reg;
    assign gen_count      = gen_count_reg;
    assign host_count     = host_count_reg;

endmodule

// File: tb/tb_voxel_write_arbiter.sv
// Directed bench for voxel_write_arbiter: a per-cycle vector table plus hand-written corner sequences.
module tb_voxel_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        gen_write_en;
    logic [17:0] gen_write_addr;
    logic [63:0] gen_write_data;
    logic        gen_busy;
    logic        host_valid;
    logic        host_ready;
    logic [17:0] host_addr;
    logic [63:0] host_data;
    logic        mem_write_en;
    logic [17:0] mem_write_addr;
    logic [63:0] mem_write_data;
    logic [2:0]  fifo_level;
    logic [19:0] gen_count;
    logic [19:0] host_count;
    logic        stat_clear;

    int passed = 0;
    int total  = 0;

    voxel_write_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gen_write_en  (gen_write_en),
        .gen_write_addr(gen_write_addr),
        .gen_write_data(gen_write_data),
        .gen_busy      (gen_busy),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .mem_write_en  (mem_write_en),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .fifo_level    (fifo_level),
        .gen_count     (gen_count),
        .host_count    (host_count),
        .stat_clear    (stat_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gen_en;
        logic [17:0] gen_addr;
        logic [63:0] gen_data;
        logic        busy;
        logic        hv;
        logic [17:0] haddr;
        logic [63:0] hdata;
        logic        e_en;
        logic [17:0] e_addr;
        logic [63:0] e_data;
        logic        e_ready;
        logic [2:0]  e_level;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t v(input logic ge, input logic [17:0] ga, input logic [63:0] gd,
                               input logic b, input logic hv, input logic [17:0] ha,
                               input logic [63:0] hd, input logic ee, input logic [17:0] ea,
                               input logic [63:0] ed, input logic er, input logic [2:0] el);
        vec_t r;
        r.gen_en = ge; r.gen_addr = ga; r.gen_data = gd; r.busy = b;
        r.hv = hv; r.haddr = ha; r.hdata = hd;
        r.e_en = ee; r.e_addr = ea; r.e_data = ed; r.e_ready = er; r.e_level = el;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic ge, input logic [17:0] ga, input logic [63:0] gd,
                         input logic b, input logic hv, input logic [17:0] ha,
                         input logic [63:0] hd, input logic clr);
        gen_write_en = ge; gen_write_addr = ga; gen_write_data = gd; gen_busy = b;
        host_valid = hv; host_addr = ha; host_data = hd; stat_clear = clr;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_mem(input string tag, input logic en, input logic [17:0] a, input logic [63:0] d);
        chk({tag, ".en"}, 64'(mem_write_en), 64'(en));
        chk({tag, ".addr"}, 64'(mem_write_addr), 64'(a));
        chk({tag, ".data"}, mem_write_data, d);
    endtask

    initial begin
        // Generator pass-through, then host fill under gen_busy, then drain with backpressure release.
        vecs[0]  = v(1, 18'h1, 64'hA, 1, 0, 0, 0,             1, 18'h1,   64'hA,  1, 3'd0);
        vecs[1]  = v(1, 18'h2, 64'hB, 1, 0, 0, 0,             1, 18'h2,   64'hB,  1, 3'd0);
        vecs[2]  = v(1, 18'h3, 64'hC, 1, 0, 0, 0,             1, 18'h3,   64'hC,  1, 3'd0);
        vecs[3]  = v(0, 0, 0,         1, 0, 0, 0,             0, 18'h3,   64'hC,  1, 3'd0);
        vecs[4]  = v(0, 0, 0,         1, 1, 18'h100, 64'hD0,  0, 18'h3,   64'hC,  1, 3'd1);
        vecs[5]  = v(0, 0, 0,         1, 1, 18'h101, 64'hD1,  0, 18'h3,   64'hC,  1, 3'd2);
        vecs[6]  = v(0, 0, 0,         1, 1, 18'h102, 64'hD2,  0, 18'h3,   64'hC,  1, 3'd3);
        vecs[7]  = v(0, 0, 0,         1, 1, 18'h103, 64'hD3,  0, 18'h3,   64'hC,  0, 3'd4);
        vecs[8]  = v(0, 0, 0,         1, 1, 18'h104, 64'hD4,  0, 18'h3,   64'hC,  0, 3'd4);
        vecs[9]  = v(0, 0, 0,         0, 1, 18'h104, 64'hD4,  1, 18'h100, 64'hD0, 1, 3'd3);
        vecs[10] = v(0, 0, 0,         0, 1, 18'h104, 64'hD4,  1, 18'h101, 64'hD1, 1, 3'd3);
        vecs[11] = v(0, 0, 0,         0, 0, 0, 0,             1, 18'h102, 64'hD2, 1, 3'd2);
        vecs[12] = v(0, 0, 0,         0, 0, 0, 0,             1, 18'h103, 64'hD3, 1, 3'd1);
        vecs[13] = v(0, 0, 0,         0, 0, 0, 0,             1, 18'h104, 64'hD4, 1, 3'd0);
        vecs[14] = v(0, 0, 0,         0, 0, 0, 0,             0, 18'h104, 64'hD4, 1, 3'd0);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        chk_mem("reset", 0, 0, 0);
        chk("reset.ready", 64'(host_ready), 0);
        chk("reset.level", 64'(fifo_level), 0);
        chk("reset.gen_count", 64'(gen_count), 0);
        chk("reset.host_count", 64'(host_count), 0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("release.ready", 64'(host_ready), 1);
        chk("release.en", 64'(mem_write_en), 0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].gen_en, vecs[i].gen_addr, vecs[i].gen_data, vecs[i].busy,
                  vecs[i].hv, vecs[i].haddr, vecs[i].hdata, 0);
            cyc();
            chk_mem($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_addr, vecs[i].e_data);
            chk($sformatf("vec%0d.ready", i), 64'(host_ready), 64'(vecs[i].e_ready));
            chk($sformatf("vec%0d.level", i), 64'(fifo_level), 64'(vecs[i].e_level));
            $display("vec %0d: en=%0b addr=%0h data=%0h ready=%0b level=%0d",
                     i, mem_write_en, mem_write_addr, mem_write_data, host_ready, fifo_level);
        end
        chk("table.gen_count", 64'(gen_count), 3);
        chk("table.host_count", 64'(host_count), 5);

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("clear.gen_count", 64'(gen_count), 0);
        chk("clear.host_count", 64'(host_count), 0);

        // Priority collision: queued edit to 0x01000 waits behind two generator writes to the same address.
        drive(0, 0, 0, 0, 1, 18'h01000, 64'h55, 0);
        cyc();
        chk("coll.level", 64'(fifo_level), 1);
        drive(1, 18'h01000, 64'h11, 0, 0, 0, 0, 0);
        cyc();
        chk_mem("coll.gen0", 1, 18'h01000, 64'h11);
        drive(1, 18'h01000, 64'h22, 0, 0, 0, 0, 0);
        cyc();
        chk_mem("coll.gen1", 1, 18'h01000, 64'h22);
        chk("coll.level_held", 64'(fifo_level), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk_mem("coll.host", 1, 18'h01000, 64'h55);
        chk("coll.host_count", 64'(host_count), 1);
        chk("coll.gen_count", 64'(gen_count), 2);
        $display("collision: host edit emitted after gen, host_count=%0d", host_count);

        // Simultaneous push/pop at level 2.
        drive(0, 0, 0, 1, 1, 18'h2000, 64'h1234_0000, 0);
        cyc();
        drive(0, 0, 0, 1, 1, 18'h2001, 64'h1234_0001, 0);
        cyc();
        chk("pp.level_start", 64'(fifo_level), 2);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 1, 18'h2000 + 18'(k + 2), 64'h1234_0000 + 64'(k + 2), 0);
            cyc();
            chk_mem($sformatf("pp%0d", k), 1, 18'h2000 + 18'(k), 64'h1234_0000 + 64'(k));
            chk($sformatf("pp%0d.level", k), 64'(fifo_level), 2);
            $display("pushpop %0d: addr=%0h level=%0d", k, mem_write_addr, fifo_level);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk_mem("pp.tail0", 1, 18'h200A, 64'h1234_000A);
        cyc();
        chk_mem("pp.tail1", 1, 18'h200B, 64'h1234_000B);
        chk("pp.level_end", 64'(fifo_level), 0);
        chk("pp.host_count", 64'(host_count), 13);

        // Counter saturation and clear-beats-increment.
        force dut.gen_count_reg = 20'hFFFFE;
        #1;
        release dut.gen_count_reg;
        drive(1, 18'h5, 64'h5, 0, 0, 0, 0, 0);
        cyc();
        chk("sat.first", 64'(gen_count), 64'hFFFFF);
        cyc();
        cyc();
        chk("sat.hold", 64'(gen_count), 64'hFFFFF);
        drive(1, 18'h6, 64'h6, 0, 0, 0, 0, 1);
        cyc();
        chk("clr_inc.gen_count", 64'(gen_count), 0);
        chk("clr_inc.host_count", 64'(host_count), 0);
        chk_mem("clr_inc.mem", 1, 18'h6, 64'h6);
        $display("saturation/clear: gen_count=%0h", gen_count);

        // Reset while a host drain is in flight.
        drive(0, 0, 0, 1, 1, 18'h3000, 64'h77, 0);
        cyc();
        drive(0, 0, 0, 1, 1, 18'h3001, 64'h78, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk_mem("mid.inflight", 1, 18'h3000, 64'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk_mem("mid.reset", 0, 0, 0);
        chk("mid.ready", 64'(host_ready), 0);
        chk("mid.level", 64'(fifo_level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("mid.release_ready", 64'(host_ready), 1);
        chk("mid.release_en", 64'(mem_write_en), 0);
        cyc();
        chk("mid.discarded_en", 64'(mem_write_en), 0);
        chk("mid.discarded_level", 64'(fifo_level), 0);
        $display("reset mid-drain: en=%0b level=%0d", mem_write_en, fifo_level);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
